key_filter: RTL and testbench

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/clock_pkg.sv | 24 ++
 rtl/key_filter_if.sv | 22 ++
 rtl/key_filter_ch.sv | 160 ++++++++++++++++
 rtl/key_filter.sv | 67 ++++++
 tb/tb_key_filter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants and types for the key_filter block: key bit positions,
// channel FSM state encoding and a width helper.
package clock_pkg;

  localparam int NUM_KEYS    = 5;
  localparam int KEY_SET_MOD = 4;
  localparam int KEY_LEFT    = 3;
  localparam int KEY_RIGHT   = 2;
  localparam int KEY_UP      = 1;
  localparam int KEY_DOWN    = 0;

  // Channel FSM state, kept as plain localparam codes for legacy tools.
  typedef logic [1:0] key_state_t;
  localparam key_state_t StIdle        = 2'd0;
  localparam key_state_t StPressWait   = 2'd1;
  localparam key_state_t StHeld        = 2'd2;
  localparam key_state_t StReleaseWait = 2'd3;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/key_filter_if.sv
// Key bundle between a keypad source and the key_filter block.
// The source drives raw levels; the filter returns debounced levels and strobes.
interface key_filter_if;
  import clock_pkg::*;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_pulse;

  modport master (
    output key_raw,
    input  key_level,
    input  key_pulse
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_pulse
  );

endinterface

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM with a saturating ms
// counter, registered level/pulse outputs. Optional auto-repeat timer is
// built only when KEY_AUTOREPEAT_EN is defined.
module key_filter_ch
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 20
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter bit          REPEAT_EN       = 1'b0
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic key_raw_i,
  output logic key_level_o,
  output logic key_pulse_o
);

  localparam int unsigned DbW = clog2_min1(DEBOUNCE_MS + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_MS);

  logic [1:0]     sync_q, sync_d;
  key_state_t     state_q, state_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [DbW-1:0] db_inc;
  logic           level_q, level_d;
  logic           pulse_q, pulse_d;
  logic           key_s;
  logic           rep_fire;

  assign key_s = sync_q[1];

  // Shift the raw key through the synchronizer.
  always_comb begin
    sync_d = {sync_q[0], key_raw_i};
  end

  // Debounce FSM; counter only advances on ms ticks and saturates at DbMax.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    pulse_d  = 1'b0;
    db_inc   = (db_cnt_q == DbMax) ? db_cnt_q : db_cnt_q + DbW'(1);
    unique case (state_q)
      StIdle: begin
        if (key_s) begin
          state_d  = StPressWait;
          db_cnt_d = '0;
        end
      end
      StPressWait: begin
        if (!key_s) begin
          state_d  = StIdle;
          db_cnt_d = '0;
        end else if (tick_i) begin
          db_cnt_d = db_inc;
          if (db_inc == DbMax) begin
            state_d = StHeld;
            pulse_d = 1'b1;
          end
        end
      end
      StHeld: begin
        if (!key_s) begin
          state_d  = StReleaseWait;
          db_cnt_d = '0;
        end
      end
      StReleaseWait: begin
        // Returning to HELD is a glitch, never a new press.
        if (key_s) begin
          state_d = StHeld;
        end else if (tick_i) begin
          db_cnt_d = db_inc;
          if (db_inc == DbMax) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (rep_fire) begin
      pulse_d = 1'b1;
    end
    level_d = (state_d == StHeld) || (state_d == StReleaseWait);
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RepMaxV = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                       : REPEAT_RATE_MS;
  localparam int unsigned RpW = clog2_min1(RepMaxV + 1);
  localparam logic [RpW-1:0] RepDelay = RpW'(REPEAT_DELAY_MS);
  localparam logic [RpW-1:0] RepRate  = RpW'(REPEAT_RATE_MS);

  logic [RpW-1:0] rep_cnt_q, rep_cnt_d;
  logic [RpW-1:0] rep_inc;
  logic           rep_armed_q, rep_armed_d;

  // Repeat timer: runs only in HELD, holds in RELEASE_WAIT, clears in IDLE.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    rep_inc     = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + RpW'(1);
    if (state_q == StIdle) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (REPEAT_EN && state_q == StHeld && key_s && tick_i) begin
      if (!rep_armed_q && rep_inc >= RepDelay) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else if (rep_armed_q && rep_inc >= RepRate) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Channel state; level and pulse are registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      state_q  <= StIdle;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
    end
  end

  assign key_level_o = level_q;
  assign key_pulse_o = pulse_q;

endmodule

// File: rtl/key_filter.sv
// Five-key debouncer: shared 1 kHz tick plus one key_filter_ch per key.
// Define KEY_AUTOREPEAT_EN to add auto-repeat strobes on the up/down keys.
module key_filter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic         clk,
  input  logic         reset,
  key_filter_if.slave  kif
);

  localparam int unsigned TickDiv = CLK_HZ / 1000;
  localparam int unsigned TickW   = clog2_min1(TickDiv);
  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);

  if (DEBOUNCE_MS == 0 || REPEAT_DELAY_MS == 0 || REPEAT_RATE_MS == 0 || TickDiv == 0)
  begin : g_bad_cfg
    $error("key_filter: timing parameters must be non-zero and CLK_HZ >= 1000");
  end

  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] pulse_w;

  // Free-running ms divider; tick is high for the last count of each period.
  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  end

  // Tick divider state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .DEBOUNCE_MS     (DEBOUNCE_MS)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS),
      .REPEAT_EN       ((i == KEY_UP) || (i == KEY_DOWN))
`endif
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick_i      (tick),
      .key_raw_i   (kif.key_raw[i]),
      .key_level_o (level_w[i]),
      .key_pulse_o (pulse_w[i])
    );
  end

  assign kif.key_level = level_w;
  assign kif.key_pulse = pulse_w;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: scoreboard of expected pulse windows per key,
// popped by a monitor whenever a key_pulse bit fires.
module tb_key_filter;
  import clock_pkg::*;

  typedef struct {
    int          key;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int unsigned now   = 0;
  int unsigned cyc   = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        sb[$];

  key_filter_if kif();

  key_filter #(
    .CLK_HZ          (10000),
    .DEBOUNCE_MS     (3),
    .REPEAT_DELAY_MS (8),
    .REPEAT_RATE_MS  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) now <= now + 1;

  // Edge count since reset release; ms ticks are consumed on multiples of 10.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, now);
    end
  endtask

  task automatic push_exp(input int key, input int unsigned lo, input int unsigned hi);
    exp_t e;
    e.key = key;
    e.lo  = now + lo;
    e.hi  = now + hi;
    sb.push_back(e);
  endtask

  // Align stimulus so the raw edge lands just after an edge with cyc%10 == 8.
  task automatic wait_phase();
    do @(negedge clk); while (cyc % 10 != 8);
  endtask

  // Scoreboard monitor: each pulse must match the oldest pending entry for its key.
  always @(negedge clk) begin : mon
    int idx;
    bit found;
    bit in_win;
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (kif.key_pulse[i]) begin
          found = 1'b0;
          idx   = 0;
          foreach (sb[j]) begin
            if (!found && sb[j].key == i) begin
              found = 1'b1;
              idx   = j;
            end
          end
          check($sformatf("pulse_expected_k%0d", i), {31'd0, found}, 32'd1);
          if (found) begin
            in_win = (now >= sb[idx].lo) && (now <= sb[idx].hi);
            check($sformatf("pulse_window_k%0d_at%0d_lo%0d_hi%0d", i, now, sb[idx].lo,
                            sb[idx].hi), {31'd0, in_win}, 32'd1);
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    kif.key_raw = '0;
    repeat (3) @(negedge clk);
    check("rst_level", {27'd0, kif.key_level}, 32'd0);
    check("rst_pulse", {27'd0, kif.key_pulse}, 32'd0);
    reset = 1'b1;

    // Clean press of up, 100 clk.
    wait_phase();
    push_exp(KEY_UP, 30, 42);
    kif.key_raw[KEY_UP] = 1'b1;
    repeat (20) @(negedge clk);
    check("up_level_debouncing", {31'd0, kif.key_level[KEY_UP]}, 32'd0);
    repeat (30) @(negedge clk);
    check("up_level_held", {31'd0, kif.key_level[KEY_UP]}, 32'd1);
    repeat (50) @(negedge clk);
    kif.key_raw[KEY_UP] = 1'b0;
    repeat (28) @(negedge clk);
    check("up_level_release_wait", {31'd0, kif.key_level[KEY_UP]}, 32'd1);
    repeat (14) @(negedge clk);
    check("up_level_released", {31'd0, kif.key_level[KEY_UP]}, 32'd0);

    // Left bouncing every 5 clk for 60 clk, then steady.
    wait_phase();
    for (int k = 0; k < 12; k++) begin
      kif.key_raw[KEY_LEFT] = (k % 2 == 0);
      repeat (5) @(negedge clk);
    end
    check("left_level_bounce", {31'd0, kif.key_level[KEY_LEFT]}, 32'd0);
    push_exp(KEY_LEFT, 30, 42);
    kif.key_raw[KEY_LEFT] = 1'b1;
    repeat (60) @(negedge clk);
    check("left_level_held", {31'd0, kif.key_level[KEY_LEFT]}, 32'd1);
    kif.key_raw[KEY_LEFT] = 1'b0;
    repeat (50) @(negedge clk);

    // Down and set_mod together.
    wait_phase();
    push_exp(KEY_DOWN, 30, 42);
    push_exp(KEY_SET_MOD, 30, 42);
    kif.key_raw[KEY_DOWN]    = 1'b1;
    kif.key_raw[KEY_SET_MOD] = 1'b1;
    for (int k = 0; k < 50 && kif.key_pulse == '0; k++) @(negedge clk);
    check("simul_pulse", {27'd0, kif.key_pulse}, 32'b10001);
    repeat (20) @(negedge clk);
    kif.key_raw = '0;
    repeat (50) @(negedge clk);

    // Up held 300 clk: one pulse, plus repeats when auto-repeat is built in.
    wait_phase();
    push_exp(KEY_UP, 30, 42);
`ifdef KEY_AUTOREPEAT_EN
    for (int j = 0; j < 10; j++) push_exp(KEY_UP, 109 + 20 * j, 115 + 20 * j);
`endif
    kif.key_raw[KEY_UP] = 1'b1;
    repeat (300) @(negedge clk);
    kif.key_raw[KEY_UP] = 1'b0;
    repeat (50) @(negedge clk);

    // Right held 300 clk: never repeats.
    wait_phase();
    push_exp(KEY_RIGHT, 30, 42);
    kif.key_raw[KEY_RIGHT] = 1'b1;
    repeat (300) @(negedge clk);
    kif.key_raw[KEY_RIGHT] = 1'b0;
    repeat (50) @(negedge clk);

    // Reset during press debounce, key still held.
    wait_phase();
    kif.key_raw[KEY_UP] = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_level", {27'd0, kif.key_level}, 32'd0);
    check("rst_mid_pulse", {27'd0, kif.key_pulse}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push_exp(KEY_UP, 28, 42);
    repeat (60) @(negedge clk);
    check("rst_requal_level", {31'd0, kif.key_level[KEY_UP]}, 32'd1);

    // Reset while held: level drops at once, no pulse.
    reset = 1'b0;
    #1;
    check("rst_held_level", {27'd0, kif.key_level}, 32'd0);
    kif.key_raw = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
